cpu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the WF8 8-bit accumulator core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB phases and handshakes with instruction and data memory. It gates the combinational decode strobes (register write, memory write, PC select) so that each one fires in exactly one phase. A watchdog on every memory wait traps the core in a FAULT state if the memory never acknowledges.

---
 rtl/cpu_sequencer.sv | 96 +++++++++
 tb/tb_cpu_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the WF8 core.
// It also runs a watchdog on memory waits that traps the core in FAULT.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       halt_req,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       dec_reg_wr,
  input  logic       dec_mem_wr,
  input  logic       dec_mem_rd,
  input  logic       dec_pc_wr,
  input  logic       branch_taken,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       alu_lat,
  output logic       reg_wr,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd7
  } state_e;
  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             timeout;
  assign timeout = cnt_q == TMO_W'(MEM_TIMEOUT);
  // The wait counter is cleared on every transition into a request state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (run) begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        if (imem_ack) state_d = DECODE;
        else if (timeout) state_d = FAULT;
        else cnt_d = cnt_q + TMO_W'(1);
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = (dec_mem_rd || dec_mem_wr) ? MEM : WB;
        cnt_d   = '0;
      end
      MEM: begin
        if (dmem_ack) state_d = WB;
        else if (timeout) state_d = FAULT;
        else cnt_d = cnt_q + TMO_W'(1);
      end
      WB: begin
        state_d = (halt_req || !run) ? IDLE : FETCH;
        cnt_d   = '0;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Strobes are decoded from the registered state so each fires in exactly one phase.
  assign imem_req = state_q == FETCH;
  assign ir_load  = imem_req && imem_ack;
  assign pc_inc   = imem_req && imem_ack;
  assign dmem_req = state_q == MEM;
  assign dmem_we  = dmem_req && dec_mem_wr;
  assign alu_lat  = state_q == EXEC;
  assign pc_load  = alu_lat && dec_pc_wr && branch_taken;
  assign reg_wr   = state_q == WB && dec_reg_wr;
  assign fault    = state_q == FAULT;
  assign busy     = state_q != IDLE && state_q != FAULT;
  assign state    = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed-vector bench for cpu_sequencer.
module tb_cpu_sequencer;
  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3, S_M = 3'd4, S_W = 3'd5, S_X = 3'd7;
  localparam logic [9:0] IREQ = 10'h200, DREQ = 10'h100, DWE = 10'h080, IRL = 10'h040, PCI = 10'h020;
  localparam logic [9:0] PCL = 10'h010, ALU = 10'h008, RW = 10'h004, BSY = 10'h002, FLT = 10'h001;
  localparam logic [9:0] FOK = IREQ | IRL | PCI | BSY;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, halt_req = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic dec_reg_wr = 1'b0, dec_mem_wr = 1'b0, dec_mem_rd = 1'b0, dec_pc_wr = 1'b0, branch_taken = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, alu_lat, reg_wr, busy, fault;
  logic [2:0] state;
  logic [9:0] outs;
  int n_tests = 0, n_fail = 0;
  assign outs = {imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, alu_lat, reg_wr, busy, fault};
  cpu_sequencer #(.MEM_TIMEOUT(15), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .dec_reg_wr(dec_reg_wr), .dec_mem_wr(dec_mem_wr), .dec_mem_rd(dec_mem_rd), .dec_pc_wr(dec_pc_wr),
    .branch_taken(branch_taken), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_lat(alu_lat), .reg_wr(reg_wr),
    .busy(busy), .fault(fault), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [2:0] s, input logic [9:0] o);
    #1;
    check({tag, ".state"}, {7'd0, state}, {7'd0, s});
    check({tag, ".outs"}, outs, o);
    @(negedge clk);
  endtask
  task automatic dec(input logic rw, input logic mw, input logic mr, input logic pw);
    dec_reg_wr = rw;
    dec_mem_wr = mw;
    dec_mem_rd = mr;
    dec_pc_wr  = pw;
  endtask
  initial begin
    run = 1'b1;
    @(negedge clk);
    step("rst", S_I, 10'h0);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    branch_taken = 1'b1;
    step("idle", S_I, 10'h0);
    for (int i = 0; i < 2; i++) begin
      step("nop_f", S_F, FOK);
      step("nop_d", S_D, BSY);
      step("nop_e", S_E, ALU | BSY);
      step("nop_w", S_W, BSY);
    end
    dec(1, 0, 0, 0);
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) step("add_wait", S_F, IREQ | BSY);
    imem_ack = 1'b1;
    step("add_f", S_F, FOK);
    imem_ack = 1'b0;
    dmem_ack = 1'b1;
    step("add_d", S_D, BSY);
    dmem_ack = 1'b0;
    step("add_e", S_E, ALU | BSY);
    step("add_w", S_W, RW | BSY);
    dec(0, 1, 0, 0);
    imem_ack = 1'b1;
    step("sb_f", S_F, FOK);
    imem_ack = 1'b0;
    step("sb_d", S_D, BSY);
    step("sb_e", S_E, ALU | BSY);
    for (int i = 0; i < 2; i++) step("sb_wait", S_M, DREQ | DWE | BSY);
    dmem_ack = 1'b1;
    step("sb_m", S_M, DREQ | DWE | BSY);
    dmem_ack = 1'b0;
    step("sb_w", S_W, BSY);
    dec(1, 0, 1, 0);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    step("lb_f", S_F, FOK);
    step("lb_d", S_D, BSY);
    step("lb_e", S_E, ALU | BSY);
    step("lb_m", S_M, DREQ | BSY);
    step("lb_w", S_W, RW | BSY);
    dec(0, 1, 1, 0);
    step("rw_f", S_F, FOK);
    step("rw_d", S_D, BSY);
    step("rw_e", S_E, ALU | BSY);
    step("rw_m", S_M, DREQ | DWE | BSY);
    dmem_ack = 1'b0;
    step("rw_w", S_W, BSY);
    dec(0, 0, 0, 1);
    step("bt_f", S_F, FOK);
    step("bt_d", S_D, BSY);
    step("bt_e", S_E, ALU | PCL | BSY);
    step("bt_w", S_W, BSY);
    branch_taken = 1'b0;
    step("bn_f", S_F, FOK);
    step("bn_d", S_D, BSY);
    step("bn_e", S_E, ALU | BSY);
    halt_req = 1'b1;
    step("bn_w", S_W, BSY);
    halt_req = 1'b0;
    step("halt_idle", S_I, 10'h0);
    dec(0, 0, 1, 0);
    step("to_f", S_F, FOK);
    imem_ack = 1'b0;
    step("to_d", S_D, BSY);
    step("to_e", S_E, ALU | BSY);
    for (int i = 0; i < 16; i++) step("to_mwait", S_M, DREQ | BSY);
    step("to_fault", S_X, FLT);
    run = 1'b0;
    step("to_run0", S_X, FLT);
    run = 1'b1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    step("to_run1", S_X, FLT);
    rst_n = 1'b0;
    step("to_rst", S_I, 10'h0);
    rst_n = 1'b1;
    dmem_ack = 1'b0;
    dec(1, 0, 1, 0);
    step("a15_idle", S_I, 10'h0);
    step("a15_f", S_F, FOK);
    imem_ack = 1'b0;
    step("a15_d", S_D, BSY);
    step("a15_e", S_E, ALU | BSY);
    for (int i = 0; i < 15; i++) step("a15_mwait", S_M, DREQ | BSY);
    dmem_ack = 1'b1;
    step("a15_m", S_M, DREQ | BSY);
    dmem_ack = 1'b0;
    step("a15_w", S_W, RW | BSY);
    for (int i = 0; i < 16; i++) step("ft_wait", S_F, IREQ | BSY);
    step("ft_fault", S_X, FLT);
    rst_n = 1'b0;
    step("ft_rst", S_I, 10'h0);
    rst_n = 1'b1;
    dec(0, 1, 0, 0);
    step("ar_idle", S_I, 10'h0);
    imem_ack = 1'b1;
    step("ar_f", S_F, FOK);
    imem_ack = 1'b0;
    step("ar_d", S_D, BSY);
    step("ar_e", S_E, ALU | BSY);
    step("ar_m", S_M, DREQ | DWE | BSY);
    #2 rst_n = 1'b0;
    #1;
    check("ar_async.state", {7'd0, state}, 10'h0);
    check("ar_async.outs", outs, 10'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    step("ar_rel", S_I, 10'h0);
    step("ar_hold", S_I, 10'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
